// File: rtl/mult_sched_pkg.sv
// Shared widths, default requester count and FSM encodings for the multiplier scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mult_sched_pkg;

    localparam int OPW      = 4;   // operand width
    localparam int PW       = 8;   // product width
    localparam int NREQ_DEF = 4;   // default number of requesters

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/multiplier.sv
// Purely combinational 4x4 unsigned multiplier shared by all requesters.
// Latency: 0 cycles (combinational).
// Backpressure: none; output follows inputs.
module multiplier (
    output logic [7:0] Product,
    input  logic [3:0] A,
    input  logic [3:0] B
);

    // zero-extend before multiplying so the full 8-bit result is kept
    assign Product = {4'b0000, A} * {4'b0000, B};

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first set req bit at or above ptr, wrapping modulo N.
// Latency: 0 cycles (combinational).
// Backpressure: en=0 forces gnt to zero.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    input  logic         en,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx
);

    logic found;
    int   idx;

    // scan N positions starting at ptr; the first valid requester wins
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = W'(idx);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_share_sched.sv
// Round-robin time-sharing of one 4x4 multiplier among NREQ requesters, one tagged registered response.
// Latency: grant in cycle T, product/id valid at T+1; one op per cycle while rsp_ready=1.
// Backpressure: while a result is held and rsp_ready=0 no requester is granted and the result holds.
// Optional statistics counters are built when MULT_SCHED_STATS_EN is defined.
module mult_share_sched
    import mult_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = $clog2(NREQ)
`ifdef MULT_SCHED_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [OPW*NREQ-1:0]   req_a,
    input  logic [OPW*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    output logic [PW-1:0]         rsp_product,
    output logic [IDW-1:0]        rsp_id,
    input  logic                  rsp_ready
`ifdef MULT_SCHED_STATS_EN
    ,
    output logic [CNT_W*NREQ-1:0] stat_grants,
    output logic [CNT_W-1:0]      stat_stall
`endif
);

    state_t           state;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   ptr_next;
    logic [NREQ-1:0]  gnt;
    logic [IDW-1:0]   gnt_idx;
    logic             gnt_any;
    logic             can_issue;
    logic [OPW-1:0]   op_a;
    logic [OPW-1:0]   op_b;
    logic [PW-1:0]    mul_out;

    // a new op may issue when the output slot is free or is being drained this cycle
    assign can_issue = (state == S_EMPTY) | rsp_ready;
    assign gnt_any   = |gnt;
    assign req_ready = gnt;

    rr_arbiter #(
        .N (NREQ),
        .W (IDW)
    ) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .en      (can_issue),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // route only the granted requester's operands into the shared multiplier
    always_comb begin
        op_a = req_a[int'(gnt_idx)*OPW +: OPW];
        op_b = req_b[int'(gnt_idx)*OPW +: OPW];
    end

    multiplier u_mul (
        .Product (mul_out),
        .A       (op_a),
        .B       (op_b)
    );

    // pointer moves one past the winner, wrapping from NREQ-1 back to 0
    assign ptr_next = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;

    // output-slot FSM with registered response and round-robin pointer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_EMPTY;
            rsp_valid   <= 1'b0;
            rsp_product <= '0;
            rsp_id      <= '0;
            rr_ptr      <= '0;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (gnt_any) begin
                        state     <= S_FULL;
                        rsp_valid <= 1'b1;
                    end
                end
                S_FULL: begin
                    if (rsp_ready && !gnt_any) begin
                        state     <= S_EMPTY;
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_EMPTY;
                    rsp_valid <= 1'b0;
                end
            endcase
            if (gnt_any) begin
                rsp_product <= mul_out;
                rsp_id      <= gnt_idx;
                rr_ptr      <= ptr_next;
            end
        end
    end

`ifdef MULT_SCHED_STATS_EN
    logic [CNT_W-1:0] grant_cnt [NREQ];
    logic [CNT_W-1:0] stall_cnt;

    // saturating per-requester grant counters and output-stall counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) begin
                grant_cnt[i] <= '0;
            end
            stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (gnt[i] && (grant_cnt[i] != '1)) begin
                    grant_cnt[i] <= grant_cnt[i] + 1'b1;
                end
            end
            if (rsp_valid && !rsp_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_stat
        assign stat_grants[g*CNT_W +: CNT_W] = grant_cnt[g];
    end
    assign stat_stall = stall_cnt;
`endif

endmodule

// File: tb/tb_mult_share_sched.sv
// Directed bench for mult_share_sched: vector table for arbitration/latency/backpressure,
// plus hand sequences for mid-operation reset and the optional statistics counters.
// Drives inputs #1 after posedge, samples grants before the next edge and responses #1 after it.
module tb_mult_share_sched;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic [7:0]  rsp_product;
    logic [1:0]  rsp_id;
    logic        rsp_ready;
`ifdef MULT_SCHED_STATS_EN
    logic [63:0] stat_grants;
    logic [15:0] stat_stall;
`endif

    int tests;
    int fails;

    mult_share_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_product (rsp_product),
        .rsp_id      (rsp_id),
        .rsp_ready   (rsp_ready)
`ifdef MULT_SCHED_STATS_EN
        ,
        .stat_grants (stat_grants),
        .stat_stall  (stat_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  vld;
        logic [15:0] a;
        logic [15:0] b;
        logic        rdy;
        logic [3:0]  exp_gnt;
        logic        exp_vld;
        logic [7:0]  exp_prod;
        logic [1:0]  exp_id;
    } vec_t;

    vec_t vecs [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // one cycle: drive, check grant combinationally, clock, check response
    task automatic apply(input int n, input vec_t v);
        req_valid = v.vld;
        req_a     = v.a;
        req_b     = v.b;
        rsp_ready = v.rdy;
        #1;
        chk($sformatf("v%0d req_ready", n), 32'(req_ready), 32'(v.exp_gnt));
        @(posedge clk);
        #1;
        chk($sformatf("v%0d rsp_valid", n), 32'(rsp_valid), 32'(v.exp_vld));
        chk($sformatf("v%0d rsp_product", n), 32'(rsp_product), 32'(v.exp_prod));
        chk($sformatf("v%0d rsp_id", n), 32'(rsp_id), 32'(v.exp_id));
    endtask

    function automatic vec_t mk(input logic [3:0] vld, input logic [15:0] a, input logic [15:0] b,
                                input logic rdy, input logic [3:0] eg, input logic ev,
                                input logic [7:0] ep, input logic [1:0] ei);
        vec_t v;
        v.vld = vld; v.a = a; v.b = b; v.rdy = rdy;
        v.exp_gnt = eg; v.exp_vld = ev; v.exp_prod = ep; v.exp_id = ei;
        return v;
    endfunction

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;

        // operands: req i has A=i+1, B=i+5 -> products 5,12,21,32
        vecs[0]  = mk(4'b1111, 16'h4321, 16'h8765, 1'b1, 4'b0001, 1'b1, 8'd5,   2'd0);
        vecs[1]  = mk(4'b1111, 16'h4321, 16'h8765, 1'b1, 4'b0010, 1'b1, 8'd12,  2'd1);
        vecs[2]  = mk(4'b1111, 16'h4321, 16'h8765, 1'b1, 4'b0100, 1'b1, 8'd21,  2'd2);
        vecs[3]  = mk(4'b1111, 16'h4321, 16'h8765, 1'b1, 4'b1000, 1'b1, 8'd32,  2'd3);
        vecs[4]  = mk(4'b1111, 16'h4321, 16'h8765, 1'b1, 4'b0001, 1'b1, 8'd5,   2'd0);
        // idle: slot drains, product holds
        vecs[5]  = mk(4'b0000, 16'h4321, 16'h8765, 1'b1, 4'b0000, 1'b0, 8'd5,   2'd0);
        // max operands from requester 0 while pointer sits at 1
        vecs[6]  = mk(4'b0001, 16'h000F, 16'h000F, 1'b1, 4'b0001, 1'b1, 8'hE1,  2'd0);
        vecs[7]  = mk(4'b0000, 16'h000F, 16'h000F, 1'b0, 4'b0000, 1'b1, 8'hE1,  2'd0);
        vecs[8]  = mk(4'b0000, 16'h000F, 16'h000F, 1'b1, 4'b0000, 1'b0, 8'hE1,  2'd0);
        // 2*5 from req 2 moves pointer to 3
        vecs[9]  = mk(4'b0100, 16'h0200, 16'h0500, 1'b1, 4'b0100, 1'b1, 8'd10,  2'd2);
        // five cycles of backpressure with req 1 (6*7) and req 3 (9*9) waiting
        vecs[10] = mk(4'b1010, 16'h9260, 16'h9570, 1'b0, 4'b0000, 1'b1, 8'd10,  2'd2);
        vecs[11] = mk(4'b1010, 16'h9260, 16'h9570, 1'b0, 4'b0000, 1'b1, 8'd10,  2'd2);
        vecs[12] = mk(4'b1010, 16'h9260, 16'h9570, 1'b0, 4'b0000, 1'b1, 8'd10,  2'd2);
        vecs[13] = mk(4'b1010, 16'h9260, 16'h9570, 1'b0, 4'b0000, 1'b1, 8'd10,  2'd2);
        vecs[14] = mk(4'b1010, 16'h9260, 16'h9570, 1'b0, 4'b0000, 1'b1, 8'd10,  2'd2);
        // release: grant in the same cycle, 3 then wrap to 1
        vecs[15] = mk(4'b1010, 16'h9260, 16'h9570, 1'b1, 4'b1000, 1'b1, 8'd81,  2'd3);
        vecs[16] = mk(4'b0010, 16'h9260, 16'h9570, 1'b1, 4'b0010, 1'b1, 8'd42,  2'd1);
        // all valid: pointer must now be 2
        vecs[17] = mk(4'b1111, 16'h9260, 16'h9570, 1'b1, 4'b0100, 1'b1, 8'd10,  2'd2);
        vecs[18] = mk(4'b0000, 16'h9260, 16'h9570, 1'b1, 4'b0000, 1'b0, 8'd10,  2'd2);

        do_reset();
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_product", 32'(rsp_product), 32'd0);
        chk("reset rsp_id", 32'(rsp_id), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            apply(i, vecs[i]);
        end

        // mid-operation reset: 11*13 held by req 2, pointer at 3 before reset
        req_valid = 4'b0100;
        req_a     = 16'h0B00;
        req_b     = 16'h0D00;
        rsp_ready = 1'b0;
        #1;
        chk("rst_seq req_ready", 32'(req_ready), 32'b0100);
        @(posedge clk);
        #1;
        chk("rst_seq held valid", 32'(rsp_valid), 32'd1);
        chk("rst_seq held product", 32'(rsp_product), 32'd143);
        chk("rst_seq held id", 32'(rsp_id), 32'd2);
        rst_n     = 1'b0;
        req_valid = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_seq after valid", 32'(rsp_valid), 32'd0);
        chk("rst_seq after product", 32'(rsp_product), 32'd0);
        chk("rst_seq after id", 32'(rsp_id), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_seq no stale rsp", 32'(rsp_valid), 32'd0);
        req_valid = 4'b1111;
        req_a     = 16'h4321;
        req_b     = 16'h8765;
        rsp_ready = 1'b1;
        #1;
        chk("rst_seq ptr zero gnt", 32'(req_ready), 32'b0001);
        @(posedge clk);
        #1;
        chk("rst_seq new product", 32'(rsp_product), 32'd5);
        req_valid = '0;
        @(posedge clk);
        #1;

`ifdef MULT_SCHED_STATS_EN
        do_reset();
        rst_n = 1'b1;
        chk("stats reset grants", 32'(stat_grants[31:0]) | 32'(stat_grants[63:32]), 32'd0);
        chk("stats reset stall", 32'(stat_stall), 32'd0);
        req_valid = 4'b0100;
        req_a     = 16'h0300;
        req_b     = 16'h0300;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("stats grants[2]", 32'(stat_grants[47:32]), 32'd3);
        chk("stats grants[0]", 32'(stat_grants[15:0]), 32'd0);
        chk("stats grants[1]", 32'(stat_grants[31:16]), 32'd0);
        chk("stats grants[3]", 32'(stat_grants[63:48]), 32'd0);
        chk("stats stall", 32'(stat_stall), 32'd4);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
